// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: forwarding selects and control bundle layout.
package id_ex_stage_pkg;

    localparam int unsigned CTRLW = 12;

    localparam int unsigned CTRL_REGWRITE = 11;
    localparam int unsigned CTRL_MEMREAD  = 10;
    localparam int unsigned CTRL_MEMWRITE = 9;
    localparam int unsigned CTRL_ALUSRC   = 8;
    localparam int unsigned CTRL_ALUOP_LO = 4;
    localparam int unsigned CTRL_WDSEL_LO = 2;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       alusrc;
        logic [3:0] aluop;
        logic [1:0] wdsel;
        logic [1:0] rsv;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// Combinational load-use detection and EX operand forwarding selection.
module id_ex_stage_hazard_unit
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned REGW = 5
) (
    input  logic            flush_i,
    input  logic            id_valid_i,
    input  logic [REGW-1:0] id_rs1_i,
    input  logic [REGW-1:0] id_rs2_i,
    input  logic            ex_valid_i,
    input  logic            ex_memread_i,
    input  logic [REGW-1:0] ex_rd_i,
    input  logic [REGW-1:0] ex_rs1_i,
    input  logic [REGW-1:0] ex_rs2_i,
    input  logic [REGW-1:0] mem_rd_i,
    input  logic            mem_regwrite_i,
    input  logic [REGW-1:0] wb_rd_i,
    input  logic            wb_regwrite_i,
    output logic            load_use_o,
    output logic            stall_o,
    output logic [1:0]      fwd_a_o,
    output logic [1:0]      fwd_b_o
);

    // x0 is hard-wired zero, so a write to it is never a real producer.
    function automatic logic hit(logic we, logic [REGW-1:0] rd, logic [REGW-1:0] rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

    always_comb begin
        load_use_o = ex_valid_i && ex_memread_i && (ex_rd_i != '0) &&
                     ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i)) && id_valid_i;
        // The flush already bubbles EX, so stalling IF/ID would lose the redirect.
        stall_o    = load_use_o && !flush_i;

        fwd_a_o = FWD_REG;
        if (hit(mem_regwrite_i, mem_rd_i, ex_rs1_i)) begin
            fwd_a_o = FWD_MEM;
        end else if (hit(wb_regwrite_i, wb_rd_i, ex_rs1_i)) begin
            fwd_a_o = FWD_WB;
        end

        fwd_b_o = FWD_REG;
        if (hit(mem_regwrite_i, mem_rd_i, ex_rs2_i)) begin
            fwd_b_o = FWD_MEM;
        end else if (hit(wb_regwrite_i, wb_rd_i, ex_rs2_i)) begin
            fwd_b_o = FWD_WB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion, bubble counter and hazard/forwarding control.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned REGW = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rd1,
    input  logic [XLEN-1:0]  id_rd2,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [REGW-1:0]  id_rs1,
    input  logic [REGW-1:0]  id_rs2,
    input  logic [REGW-1:0]  id_rd,
    input  logic [CTRLW-1:0] id_ctrl,
    input  logic [REGW-1:0]  mem_rd,
    input  logic             mem_regwrite,
    input  logic [REGW-1:0]  wb_rd,
    input  logic             wb_regwrite,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rd1,
    output logic [XLEN-1:0]  ex_rd2,
    output logic [XLEN-1:0]  ex_imm,
    output logic [REGW-1:0]  ex_rs1,
    output logic [REGW-1:0]  ex_rs2,
    output logic [REGW-1:0]  ex_rd,
    output logic [CTRLW-1:0] ex_ctrl,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             stall_ifid,
    output logic [31:0]      bubble_cnt
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [REGW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    ctrl_t           ctrl_q, ctrl_d;
    logic [31:0]     bubble_cnt_q, bubble_cnt_d;
    logic            load_use;

    id_ex_stage_hazard_unit #(
        .REGW(REGW)
    ) u_hazard (
        .flush_i        (flush),
        .id_valid_i     (id_valid),
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .ex_valid_i     (valid_q),
        .ex_memread_i   (ctrl_q.memread),
        .ex_rd_i        (rd_q),
        .ex_rs1_i       (rs1_q),
        .ex_rs2_i       (rs2_q),
        .mem_rd_i       (mem_rd),
        .mem_regwrite_i (mem_regwrite),
        .wb_rd_i        (wb_rd),
        .wb_regwrite_i  (wb_regwrite),
        .load_use_o     (load_use),
        .stall_o        (stall_ifid),
        .fwd_a_o        (fwd_a_sel),
        .fwd_b_o        (fwd_b_sel)
    );

    always_comb begin
        valid_d      = valid_q;
        pc_d         = pc_q;
        rd1_d        = rd1_q;
        rd2_d        = rd2_q;
        imm_d        = imm_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        ctrl_d       = ctrl_q;
        bubble_cnt_d = bubble_cnt_q;
        // A flush seen during hold is intentionally dropped; EX re-raises it afterwards.
        if (!hold) begin
            if (flush || load_use) begin
                valid_d      = 1'b0;
                pc_d         = '0;
                rd1_d        = '0;
                rd2_d        = '0;
                imm_d        = '0;
                rs1_d        = '0;
                rs2_d        = '0;
                rd_d         = '0;
                ctrl_d       = '0;
                bubble_cnt_d = bubble_cnt_q + 32'd1;
            end else begin
                valid_d = id_valid;
                pc_d    = id_pc;
                rd1_d   = id_rd1;
                rd2_d   = id_rd2;
                imm_d   = id_imm;
                rs1_d   = id_rs1;
                rs2_d   = id_rs2;
                rd_d    = id_rd;
                ctrl_d  = id_valid ? ctrl_t'(id_ctrl) : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            imm_q        <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            ctrl_q       <= '0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            imm_q        <= imm_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            ctrl_q       <= ctrl_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_pc      = pc_q;
    assign ex_rd1     = rd1_q;
    assign ex_rd2     = rd2_q;
    assign ex_imm     = imm_q;
    assign ex_rs1     = rs1_q;
    assign ex_rs2     = rs2_q;
    assign ex_rd      = rd_q;
    assign ex_ctrl    = ctrl_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule
